// File: rtl/obstacle_field_if.sv
// Game-FSM / draw-stage bundle for the obstacle field controller.
// The master drives start and player position; the slave (controller) returns obstacle state.
interface obstacle_field_if #(
  parameter int N_OBST = 2
);
  logic                  start;
  logic [11:0]           player_ypos;
  logic [12*N_OBST-1:0]  obst_xpos;
  logic [12*N_OBST-1:0]  obst_gap_y;
  logic [N_OBST-1:0]     obst_active;
  logic                  endgame;
  logic [15:0]           score;

  modport master (
    output start, player_ypos,
    input  obst_xpos, obst_gap_y, obst_active, endgame, score
  );

  modport slave (
    input  start, player_ypos,
    output obst_xpos, obst_gap_y, obst_active, endgame, score
  );
endinterface

// File: rtl/obstacle_field_ctl.sv
// Multi-slot obstacle controller: spawns, scrolls and retires obstacles, flags player collisions.
// Every output is registered; a collision shows on endgame one cycle after it is seen.
module obstacle_field_ctl #(
  parameter int N_OBST      = 2,
  parameter int STEP_CYCLES = 4_000_000,
  parameter int SPAWN_TICKS = 250,
  parameter int X_START     = 750,
  parameter int OBST_W      = 40,
  parameter int GAP_H       = 190,
  parameter int GAP_BASE    = 100,
  parameter int REC_W       = 64,
  parameter int REC_H       = 64
) (
  input  logic            clk,
  input  logic            rst,
  obstacle_field_if.slave bus
);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int IW = (N_OBST > 1) ? $clog2(N_OBST) : 1;

  if (N_OBST < 1 || OBST_W < 1 || X_START + OBST_W > 4095 || GAP_BASE + 255 > 4095) begin : g_bad_params
    $error("obstacle_field_ctl: slot count, obstacle extent or gap range does not fit 12-bit coordinates");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [SW-1:0]     spawn_cnt;
  logic [7:0]        lfsr;
  logic [11:0]       xpos  [N_OBST];
  logic [11:0]       gap_y [N_OBST];
  logic [N_OBST-1:0] active;
  logic              endgame_q;
  logic [15:0]       score_q;

  logic              tick;
  logic              hit;
  logic [N_OBST-1:0] hit_vec;
  logic              spawn_ok;
  logic [IW-1:0]     spawn_idx;
  logic [15:0]       score_nxt;
  logic              lfsr_fb;
  logic [12:0]       ply_top;
  logic [12:0]       ply_bot;

  assign tick    = (state == S_RUN) && (tick_cnt == TW'(STEP_CYCLES - 1));
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign ply_top = {1'b0, bus.player_ypos};
  assign ply_bot = {1'b0, bus.player_ypos} + 13'(REC_H);

  // 13-bit compares so neither the player bottom nor the gap bottom can wrap.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_OBST; i++) begin
      hit_vec[i] = active[i]
                && ({1'b0, xpos[i]} <= 13'(REC_W))
                && ((ply_top < {1'b0, gap_y[i]})
                 || (ply_bot > ({1'b0, gap_y[i]} + 13'(GAP_H))));
    end
    hit = (state == S_RUN) && (|hit_vec);
  end

  // Free-slot search uses the pre-tick mask, so a slot retired this tick stays unavailable.
  always_comb begin
    spawn_ok  = 1'b0;
    spawn_idx = '0;
    for (int i = N_OBST - 1; i >= 0; i--) begin
      if (!active[i]) begin
        spawn_ok  = 1'b1;
        spawn_idx = IW'(i);
      end
    end
  end

  always_comb begin
    score_nxt = score_q;
    for (int i = 0; i < N_OBST; i++) begin
      if (active[i] && (xpos[i] == 12'd0) && (score_nxt != 16'hFFFF)) begin
        score_nxt = score_nxt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      spawn_cnt <= '0;
      lfsr      <= 8'hA5;
      active    <= '0;
      endgame_q <= 1'b0;
      score_q   <= '0;
      for (int i = 0; i < N_OBST; i++) begin
        xpos[i]  <= '0;
        gap_y[i] <= '0;
      end
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        S_IDLE: begin
          endgame_q <= 1'b0;
          if (bus.start) begin
            state     <= S_RUN;
            score_q   <= '0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
          end
        end
        S_RUN: begin
          if (hit) begin
            // The whole field freezes; this cycle's move/retire/spawn is dropped.
            state     <= S_END;
            endgame_q <= 1'b1;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              for (int i = 0; i < N_OBST; i++) begin
                if (active[i]) begin
                  if (xpos[i] == 12'd0) begin
                    active[i] <= 1'b0;
                  end else begin
                    xpos[i] <= xpos[i] - 12'd1;
                  end
                end
              end
              score_q <= score_nxt;
              if (spawn_cnt == '0) begin
                if (spawn_ok) begin
                  active[spawn_idx] <= 1'b1;
                  xpos[spawn_idx]   <= 12'(X_START);
                  gap_y[spawn_idx]  <= 12'(GAP_BASE) + {4'b0, lfsr};
                  spawn_cnt         <= SW'(SPAWN_TICKS - 1);
                end
              end else begin
                spawn_cnt <= spawn_cnt - 1'b1;
              end
            end
          end
        end
        S_END: begin
          endgame_q <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          endgame_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_OBST; g++) begin : g_pack
    assign bus.obst_xpos[12*g +: 12]  = xpos[g];
    assign bus.obst_gap_y[12*g +: 12] = gap_y[g];
  end

  assign bus.obst_active = active;
  assign bus.endgame     = endgame_q;
  assign bus.score       = score_q;
endmodule
